// File: rtl/dmem_mmio_responder_if.sv
// Memory-stage data port between the core and the data-memory/MMIO responder.
// The core drives the access; the responder returns the read word in the same cycle.
interface dmem_mmio_responder_if;
  logic        MemWriteM;
  logic [1:0]  StoreSizeM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;

  modport master (
    output MemWriteM,
    output StoreSizeM,
    output ALUResultM,
    output WriteDataM,
    input  ReadDataM
  );

  modport slave (
    input  MemWriteM,
    input  StoreSizeM,
    input  ALUResultM,
    input  WriteDataM,
    output ReadDataM
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data-memory / MMIO responder for the M stage.
// Decodes each access to word RAM, a small MMIO bank (LED, switches, cycle
// counter with compare, sticky status) or unmapped space. Reads are
// combinational and show pre-edge contents; stores commit on the rising edge.
module dmem_mmio_responder #(
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_mmio_responder_if.slave bus,
  input  logic [15:0]          sw_i,
  output logic [15:0]          led_o,
  output logic                 irq_timer_o
);

  localparam int          AW        = $clog2(DMEM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DMEM_WORDS);

  // Byte-lane enables for a store of the given size at the given lane
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << lane;
      2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  logic [31:0] mem_q [DMEM_WORDS];

  logic [15:0] led_q, led_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] cmp_q, cmp_d;
  logic [2:0]  status_q, status_d;
  logic [15:0] sw_meta_q, sw_sync_q;

  logic          is_ram_s, is_mmio_s, is_word_s, misal_s;
  logic          ram_we_s, mmio_we_s, err_mis_s, err_unm_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;
  logic [AW-1:0] widx_s;
  logic [2:0]    clr_s;
  logic [31:0]   rdata_s;

  // Region decode, alignment check and store qualification
  always_comb begin
    is_ram_s  = (bus.ALUResultM < RAM_BYTES);
    is_mmio_s = (bus.ALUResultM[31:5] == MMIO_BASE[31:5]);
    is_word_s = bus.StoreSizeM[1];
    misal_s   = ((bus.StoreSizeM == 2'b01) && bus.ALUResultM[0]) ||
                (is_word_s && (bus.ALUResultM[1:0] != 2'b00));
    ram_we_s  = bus.MemWriteM && !misal_s && is_ram_s;
    mmio_we_s = bus.MemWriteM && !misal_s && is_mmio_s && is_word_s;
    // Sub-word stores into MMIO are silently dropped, even when misaligned
    err_mis_s = bus.MemWriteM && misal_s && !(is_mmio_s && !is_word_s);
    err_unm_s = bus.MemWriteM && !misal_s && !is_ram_s && !is_mmio_s;
    widx_s    = bus.ALUResultM[AW+1:2];
    be_s      = lane_mask(bus.StoreSizeM, bus.ALUResultM[1:0]);
    case (bus.StoreSizeM)
      2'b00:   wdata_s = {4{bus.WriteDataM[7:0]}};
      2'b01:   wdata_s = {2{bus.WriteDataM[15:0]}};
      default: wdata_s = bus.WriteDataM;
    endcase
  end

  // RAM byte-lane write; contents are not reset and a store under reset is dropped
  always_ff @(posedge clk) begin
    if (rst && ram_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[widx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  // Combinational read mux; shows pre-edge contents during a same-cycle store
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (is_ram_s) begin
      rdata_s = mem_q[widx_s];
    end else if (is_mmio_s) begin
      case (bus.ALUResultM[4:2])
        3'd0:    rdata_s = {16'h0000, led_q};
        3'd1:    rdata_s = {16'h0000, sw_sync_q};
        3'd2:    rdata_s = cyc_q;
        3'd3:    rdata_s = cmp_q;
        3'd4:    rdata_s = {29'h0000_0000, status_q};
        default: rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign bus.ReadDataM = rdata_s;

  // MMIO register next state: software writes, free-running counter, sticky status
  always_comb begin
    led_d = led_q;
    cyc_d = cyc_q + 32'd1;
    cmp_d = cmp_q;
    clr_s = 3'b000;
    if (mmio_we_s) begin
      case (bus.ALUResultM[4:2])
        3'd0:    led_d = bus.WriteDataM[15:0];
        3'd2:    cyc_d = bus.WriteDataM;
        3'd3:    cmp_d = bus.WriteDataM;
        3'd4:    clr_s = bus.WriteDataM[2:0];
        default: led_d = led_q;
      endcase
    end else begin
      clr_s = 3'b000;
    end
    // Set terms are OR-ed after the clear so a same-cycle event wins over W1C
    status_d = {err_unm_s, err_mis_s, (cyc_q == cmp_q)} | (status_q & ~clr_s);
  end

  // MMIO registers and the two-flop switch synchroniser
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q     <= 16'h0000;
      cyc_q     <= 32'h0000_0000;
      cmp_q     <= 32'hFFFF_FFFF;
      status_q  <= 3'b000;
      sw_meta_q <= 16'h0000;
      sw_sync_q <= 16'h0000;
    end else begin
      led_q     <= led_d;
      cyc_q     <= cyc_d;
      cmp_q     <= cmp_d;
      status_q  <= status_d;
      sw_meta_q <= sw_i;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign led_o       = led_q;
  assign irq_timer_o = status_q[0];

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: directed scenarios followed by
// randomized traffic, all compared against a byte-addressed behavioural model.
module tb_dmem_mmio_responder;

  localparam logic [31:0] MB = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw_i;
  logic [15:0] led_o;
  logic        irq_timer_o;

  dmem_mmio_responder_if bus_if ();

  dmem_mmio_responder dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .sw_i        (sw_i),
    .led_o       (led_o),
    .irq_timer_o (irq_timer_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  logic [7:0]  m_mem   [4096];
  bit          m_binit [4096];
  logic [15:0] m_led, m_sw1, m_sw2;
  logic [31:0] m_cyc, m_cmp;
  logic [2:0]  m_status;

  logic [31:0] rd_obs;
  logic        irq_obs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_led = 16'h0; m_cyc = 32'h0; m_cmp = 32'hFFFF_FFFF; m_status = 3'b0;
    m_sw1 = 16'h0; m_sw2 = 16'h0;
  endtask

  function automatic bit in_ram(input logic [31:0] a);
    return a < 32'd4096;
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
    return (a >= MB) && (a < MB + 32'd32);
  endfunction

  function automatic bit model_readable(input logic [31:0] a);
    int b;
    if (!in_ram(a)) return 1'b1;
    b = int'(a) & ~3;
    return m_binit[b] && m_binit[b+1] && m_binit[b+2] && m_binit[b+3];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int b;
    if (in_ram(a)) begin
      b = int'(a) & ~3;
      return {m_mem[b+3], m_mem[b+2], m_mem[b+1], m_mem[b]};
    end
    if (in_mmio(a)) begin
      case ((a - MB) / 4)
        0: return {16'h0, m_led};
        1: return {16'h0, m_sw2};
        2: return m_cyc;
        3: return m_cmp;
        4: return {29'h0, m_status};
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  // one rising edge of the modelled system with the given access presented
  task automatic model_edge(input bit we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bit          hit;
    bit          misal;
    int          nbytes;
    logic [2:0]  set_b;
    logic [2:0]  clr_b;
    logic [31:0] next_cyc;
    hit      = (m_cyc == m_cmp);
    set_b    = 3'b000;
    clr_b    = 3'b000;
    next_cyc = m_cyc + 32'd1;
    nbytes   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    misal    = (a % nbytes) != 0;
    if (we) begin
      if (misal) begin
        if (!(in_mmio(a) && nbytes < 4)) set_b[1] = 1'b1;
      end else if (in_ram(a)) begin
        for (int k = 0; k < nbytes; k++) begin
          m_mem[int'(a) + k]   = d[8*k +: 8];
          m_binit[int'(a) + k] = 1'b1;
        end
      end else if (in_mmio(a)) begin
        if (nbytes == 4) begin
          case ((a - MB) / 4)
            0: m_led = d[15:0];
            2: next_cyc = d;
            3: m_cmp = d;
            4: clr_b = d[2:0];
            default: ;
          endcase
        end
      end else begin
        set_b[2] = 1'b1;
      end
    end
    m_status = set_b | {2'b00, hit} | (m_status & ~clr_b);
    m_cyc    = next_cyc;
    m_sw2    = m_sw1;
    m_sw1    = sw_i;
  endtask

  // present one access for one cycle, check outputs before the edge, advance model
  task automatic step(input bit we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus_if.MemWriteM  = we;
    bus_if.StoreSizeM = sz;
    bus_if.ALUResultM = a;
    bus_if.WriteDataM = d;
    #1;
    rd_obs  = bus_if.ReadDataM;
    irq_obs = irq_timer_o;
    if (model_readable(a)) check_eq("rdata", rd_obs, model_read(a));
    check_eq("led", {16'h0, led_o}, {16'h0, m_led});
    check_eq("irq", {31'h0, irq_obs}, {31'h0, m_status[0]});
    @(posedge clk);
    model_edge(we, sz, a, d);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b0, 2'b10, a, 32'h0);
  endtask

  task automatic wr(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    step(1'b1, sz, a, d);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    int          kind;

    for (int i = 0; i < 4096; i++) m_binit[i] = 1'b0;
    model_reset();
    rst = 1'b0; sw_i = 16'h0;
    bus_if.MemWriteM = 1'b0; bus_if.StoreSizeM = 2'b10;
    bus_if.ALUResultM = 32'h0; bus_if.WriteDataM = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_led", {16'h0, led_o}, 32'h0);
    check_eq("rst_irq", {31'h0, irq_timer_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // reset values and free-running counter
    rd(MB + 32'h00); check_eq("t1_led", rd_obs, 32'h0);
    rd(MB + 32'h0C); check_eq("t1_cmp", rd_obs, 32'hFFFF_FFFF);
    rd(MB + 32'h10); check_eq("t1_status", rd_obs, 32'h0);
    repeat (7) rd(MB + 32'h04);
    rd(MB + 32'h08); check_eq("t1_cycle10", rd_obs, 32'd10);

    // fill the low RAM window so later reads have known contents
    for (int w = 0; w < 32; w++) wr(2'b10, 32'(w * 4), $urandom);

    // sub-word merge
    wr(2'b10, 32'h40, 32'hA1B2_C3D4);
    wr(2'b00, 32'h41, 32'h0000_00EE);
    wr(2'b01, 32'h42, 32'h0000_1234);
    rd(32'h40); check_eq("t2_merge", rd_obs, 32'h1234_EED4);

    // misaligned store, then W1C
    wr(2'b01, 32'h43, 32'h0000_5555);
    rd(32'h40); check_eq("t3_unchanged", rd_obs, 32'h1234_EED4);
    rd(MB + 32'h10); check_eq("t3_status", rd_obs, 32'h2);
    wr(2'b10, MB + 32'h10, 32'h2);
    rd(MB + 32'h10); check_eq("t3_cleared", rd_obs, 32'h0);

    // RAM top boundary and first unmapped byte past it
    wr(2'b10, 32'hFFC, 32'hCAFE_F00D);
    rd(32'hFFC); check_eq("top_word", rd_obs, 32'hCAFE_F00D);
    wr(2'b10, 32'h1000, 32'h1);
    rd(MB + 32'h10); check_eq("past_ram_err", rd_obs, 32'h4);
    wr(2'b10, MB + 32'h10, 32'h7);

    // timer compare
    wr(2'b10, MB + 32'h08, 32'd15);
    wr(2'b10, MB + 32'h0C, 32'd20);
    for (int j = 0; j < 7; j++) begin
      rd(MB + 32'h10);
      if (j == 4) check_eq("t4_irq_before", {31'h0, irq_obs}, 32'h0);
      if (j >= 5) check_eq("t4_irq_sticky", {31'h0, irq_obs}, 32'h1);
    end
    wr(2'b10, MB + 32'h10, 32'h1);
    rd(MB + 32'h10); check_eq("t4_irq_cleared", {31'h0, irq_obs}, 32'h0);
    wr(2'b10, MB + 32'h0C, m_cyc + 32'd3);
    rd(MB + 32'h08);
    rd(MB + 32'h08);
    wr(2'b10, MB + 32'h10, 32'h1);
    rd(MB + 32'h10); check_eq("t4_set_wins", {31'h0, irq_obs}, 32'h1);
    wr(2'b10, MB + 32'h0C, 32'hFFFF_FFF0);
    wr(2'b10, MB + 32'h10, 32'h7);

    // counter wrap
    wr(2'b10, MB + 32'h08, 32'hFFFF_FFFE);
    rd(MB + 32'h08); check_eq("t5_fe", rd_obs, 32'hFFFF_FFFE);
    rd(MB + 32'h08); check_eq("t5_ff", rd_obs, 32'hFFFF_FFFF);
    rd(MB + 32'h08); check_eq("t5_wrap", rd_obs, 32'h0);
    wr(2'b10, MB + 32'h10, 32'h7);

    // switch synchroniser latency
    sw_i = 16'h5A5A;
    rd(MB + 32'h04); check_eq("t6_sw0", rd_obs, 32'h0);
    rd(MB + 32'h04); check_eq("t6_sw1", rd_obs, 32'h0);
    rd(MB + 32'h04); check_eq("t6_sw2", rd_obs, 32'h5A5A);

    // unmapped store
    wr(2'b10, 32'h2000_0000, 32'h1234_5678);
    check_eq("t6_unm_rd", rd_obs, 32'h0);
    rd(MB + 32'h10); check_eq("t6_unm_err", {31'h0, rd_obs[2]}, 32'h1);

    // LED then asynchronous reset; a store held under reset is lost
    wr(2'b10, MB + 32'h00, 32'h0000_BEEF);
    check_eq("t6_led", {16'h0, led_o}, 32'h0000_BEEF);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_led_async", {16'h0, led_o}, 32'h0);
    model_reset();
    bus_if.MemWriteM = 1'b1; bus_if.StoreSizeM = 2'b10;
    bus_if.ALUResultM = 32'h44; bus_if.WriteDataM = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus_if.MemWriteM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rd(32'h44);
    rd(MB + 32'h08); check_eq("rst_cycle", rd_obs, 32'd1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) sw_i = 16'($urandom);
      kind = $urandom_range(0, 99);
      sz   = 2'($urandom_range(0, 3));
      d    = $urandom;
      if (kind < 30) begin
        wr(sz, 32'($urandom_range(0, 127)), d);
      end else if (kind < 50) begin
        rd(32'($urandom_range(0, 127)));
      end else if (kind < 65) begin
        rd(MB + 32'($urandom_range(0, 31)));
      end else if (kind < 80) begin
        case ($urandom_range(0, 4))
          0: a = MB + 32'h00;
          1: a = MB + 32'h04;
          2: begin a = MB + 32'h08; if (d[0]) d = 32'hFFFF_FFF0 | 32'(d[3:0]); end
          3: begin a = MB + 32'h0C; d = m_cyc + 32'($urandom_range(1, 6)); end
          default: begin a = MB + 32'h10; d = 32'($urandom_range(0, 7)); end
        endcase
        if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
        wr(2'b10, a, d);
      end else if (kind < 87) begin
        wr(2'($urandom_range(0, 1)), MB + 32'($urandom_range(0, 31)), d);
      end else if (kind < 95) begin
        case ($urandom_range(0, 2))
          0: a = 32'h1000 + 32'($urandom_range(0, 255));
          1: a = MB + 32'h20 + 32'($urandom_range(0, 63));
          default: a = 32'h2000_0000 + 32'($urandom);
        endcase
        step(kind[0], sz, a, d);
      end else begin
        rd(32'($urandom_range(0, 127)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
